// File: rtl/filter_frame_controller.sv
// Frame-boundary sequencer for the RGB444 effect filters: owns use_flags and
// the shared freq_flag, committing changes only between frames.
module filter_frame_controller #(
  parameter  int NUM_FILTERS = 4,
  parameter  int HOLD_FRAMES = 2,
  localparam int SW = (NUM_FILTERS > 1) ? $clog2(NUM_FILTERS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [SW-1:0]          filter_sel_req,
  input  logic                   fx_enable,
  input  logic [1:0]             freq_flag_in,
  input  logic                   sop,
  input  logic                   eop,
  input  logic                   valid,
  input  logic                   ready,
  output logic [NUM_FILTERS-1:0] use_flags,
  output logic [1:0]             freq_flag_out,
  output logic                   frame_active,
  output logic [15:0]            frame_count,
  output logic                   pending
);

  localparam int SKW = $clog2(HOLD_FRAMES + 1);
  localparam logic [SKW-1:0] HOLD_V = SKW'(HOLD_FRAMES);
  localparam logic [SKW-1:0] ONE_V  = SKW'(1);
  localparam logic [SKW-1:0] MAX_V  = '1;

  typedef enum logic {WAIT_SOP, IN_FRAME} state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [NUM_FILTERS-1:0] r_use;
  logic [1:0]             r_freq;
  logic [1:0]             r_cand;
  logic [SKW-1:0]         r_streak;
  logic                   r_active;
  logic [15:0]            r_count;
  logic                   r_pending;

  logic                   w_sop_b;
  logic                   w_eop_b;
  logic                   w_in;
  logic                   w_boundary;
  logic                   w_idle;
  logic [NUM_FILTERS-1:0] w_req;
  logic [NUM_FILTERS-1:0] w_use_nxt;
  logic [1:0]             w_freq_nxt;
  logic [1:0]             w_cand_nxt;
  logic [SKW-1:0]         w_streak_nxt;
  logic [SKW-1:0]         w_streak_inc;

  always_comb begin
    w_sop_b    = valid && ready && sop;
    w_eop_b    = valid && ready && eop;
    w_in       = (r_state == IN_FRAME);
    w_boundary = w_in ? (w_sop_b || w_eop_b) : (w_sop_b && w_eop_b);
    w_idle     = !w_in && !w_sop_b;
    if (w_in)
      w_state_nxt = w_eop_b ? WAIT_SOP : IN_FRAME;
    else
      w_state_nxt = (w_sop_b && !w_eop_b) ? IN_FRAME : WAIT_SOP;
    w_req     = fx_enable ? (NUM_FILTERS'(1) << filter_sel_req) : '0;
    w_use_nxt = (w_idle || w_boundary) ? w_req : r_use;
  end

  // Idle tracks the live level; boundaries go through the streak filter.
  always_comb begin
    w_freq_nxt   = r_freq;
    w_cand_nxt   = r_cand;
    w_streak_nxt = r_streak;
    w_streak_inc = (r_streak == MAX_V) ? r_streak : r_streak + ONE_V;
    if (w_idle) begin
      w_freq_nxt   = freq_flag_in;
      w_cand_nxt   = freq_flag_in;
      w_streak_nxt = '0;
    end else if (w_boundary) begin
      if (freq_flag_in == r_freq) begin
        w_streak_nxt = '0;
      end else begin
        if (freq_flag_in == r_cand) begin
          w_streak_nxt = w_streak_inc;
        end else begin
          w_cand_nxt   = freq_flag_in;
          w_streak_nxt = ONE_V;
        end
        if (w_streak_nxt >= HOLD_V) begin
          w_freq_nxt   = w_cand_nxt;
          w_streak_nxt = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= WAIT_SOP;
      r_use     <= '0;
      r_freq    <= '0;
      r_cand    <= '0;
      r_streak  <= '0;
      r_active  <= 1'b0;
      r_count   <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_use     <= w_use_nxt;
      r_freq    <= w_freq_nxt;
      r_cand    <= w_cand_nxt;
      r_streak  <= w_streak_nxt;
      r_active  <= (w_state_nxt == IN_FRAME);
      r_pending <= (w_req != w_use_nxt) || (freq_flag_in != w_freq_nxt);
      if (w_boundary)
        r_count <= r_count + 16'd1;
    end
  end

  assign use_flags     = r_use;
  assign freq_flag_out = r_freq;
  assign frame_active  = r_active;
  assign frame_count   = r_count;
  assign pending       = r_pending;

endmodule

// File: tb/tb_filter_frame_controller.sv
// Bench for filter_frame_controller: directed frames against a frame-level
// reference model, plus literal checkpoints.
module tb_filter_frame_controller;

  localparam int NF = 4;
  localparam int HF = 2;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [1:0]    sel = 2'd2;
  logic          fx = 1'b1;
  logic [1:0]    fin = 2'd3;
  logic          sop = 1'b0;
  logic          eop = 1'b0;
  logic          valid = 1'b0;
  logic          ready = 1'b1;
  logic [NF-1:0] use_flags;
  logic [1:0]    freq_out;
  logic          active;
  logic [15:0]   count;
  logic          pend;

  int n_checks = 0;
  int n_fail   = 0;
  bit done     = 1'b0;

  filter_frame_controller #(
    .NUM_FILTERS(NF),
    .HOLD_FRAMES(HF)
  ) dut (
    .clk(clk),
    .reset(reset),
    .filter_sel_req(sel),
    .fx_enable(fx),
    .freq_flag_in(fin),
    .sop(sop),
    .eop(eop),
    .valid(valid),
    .ready(ready),
    .use_flags(use_flags),
    .freq_flag_out(freq_out),
    .frame_active(active),
    .frame_count(count),
    .pending(pend)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: frame-level view of what should be committed.
  bit inside_frame = 0;
  int m_use = 0, m_freq = 0, m_cand = 0, m_streak = 0;
  int m_count = 0, m_active = 0, m_pend = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      inside_frame = 0;
      m_use = 0; m_freq = 0; m_cand = 0; m_streak = 0;
      m_count = 0; m_active = 0; m_pend = 0;
    end else begin
      bit accepted, s, e, finished, quiet;
      int want;
      accepted = valid && ready;
      s        = accepted && sop;
      e        = accepted && eop;
      finished = inside_frame ? (s || e) : (s && e);
      quiet    = !inside_frame && !s;
      want     = fx ? (1 << sel) : 0;
      if (quiet || finished) m_use = want;
      if (quiet) begin
        m_freq = fin; m_cand = fin; m_streak = 0;
      end else if (finished) begin
        if (fin == m_freq) m_streak = 0;
        else begin
          if (fin == m_cand) m_streak = (m_streak < 3) ? m_streak + 1 : 3;
          else begin m_cand = fin; m_streak = 1; end
          if (m_streak >= HF) begin m_freq = m_cand; m_streak = 0; end
        end
      end
      if (finished) m_count = (m_count + 1) % 65536;
      if (inside_frame) inside_frame = !e;
      else              inside_frame = s && !e;
      m_active = inside_frame;
      m_pend   = (want != m_use) || (fin != m_freq);
    end
  end

  always @(negedge clk) begin
    if (!done) begin
      chk("use_flags", use_flags, m_use);
      chk("freq_flag_out", freq_out, m_freq);
      chk("frame_active", active, m_active);
      chk("frame_count", count, m_count);
      chk("pending", pend, m_pend);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input bit s, input bit e, input bit rnd);
    bit acc;
    acc = 1'b0;
    valid = 1'b1; sop = s; eop = e;
    for (int k = 0; k < 200 && !acc; k++) begin
      ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
      acc = ready;
      tick();
    end
    if (!acc) chk("beat_timeout", 0, 1);
    valid = 1'b0; sop = 1'b0; eop = 1'b0; ready = 1'b1;
  endtask

  task automatic send_frame(input int len, input bit rnd);
    beat(1'b1, len == 1, rnd);
    for (int i = 1; i < len; i++) beat(1'b0, i == len - 1, rnd);
  endtask

  initial begin
    // Reset and idle commit
    #20;
    chk("rst_use", use_flags, 0);
    chk("rst_freq", freq_out, 0);
    chk("rst_pend", pend, 0);
    #20;
    reset = 1'b0;
    tick();
    chk("idle_use", use_flags, 4'b0100);
    chk("idle_freq", freq_out, 3);
    chk("idle_count", count, 0);
    chk("idle_pend", pend, 0);

    // Mid-frame freeze
    sel = 2'd0;
    tick();
    beat(1'b1, 1'b0, 1'b0);
    chk("frz_active", active, 1);
    beat(1'b0, 1'b0, 1'b0);
    sel = 2'd1;
    beat(1'b0, 1'b0, 1'b0);
    chk("frz_use_held", use_flags, 4'b0001);
    chk("frz_pend", pend, 1);
    beat(1'b0, 1'b1, 1'b0);
    chk("frz_use_commit", use_flags, 4'b0010);
    chk("frz_pend_clr", pend, 0);
    chk("frz_count", count, 1);
    chk("frz_inactive", active, 0);

    // Hysteresis over back-to-back frames
    fin = 2'd0;
    tick();
    chk("hys_base", freq_out, 0);
    fin = 2'd2;
    send_frame(3, 1'b0);
    chk("hys_b1", freq_out, 0);
    fin = 2'd1;
    send_frame(3, 1'b0);
    chk("hys_b2", freq_out, 0);
    send_frame(3, 1'b0);
    chk("hys_b3", freq_out, 1);
    chk("hys_count", count, 4);
    tick();

    // Stalled sink
    for (int f = 0; f < 5; f++) begin
      sel = 2'(f);
      send_frame(3 + f, 1'b1);
      tick();
    end
    chk("stall_count", count, 9);

    // Malformed frames
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    sel = 2'd3;
    beat(1'b1, 1'b0, 1'b0);
    chk("resop_count", count, 10);
    chk("resop_active", active, 1);
    chk("resop_use", use_flags, 4'b1000);
    beat(1'b0, 1'b1, 1'b0);
    chk("close_count", count, 11);
    sel = 2'd1;
    tick();
    sel = 2'd2;
    beat(1'b1, 1'b1, 1'b0);
    chk("single_count", count, 12);
    chk("single_active", active, 0);
    chk("single_use", use_flags, 4'b0100);
    beat(1'b0, 1'b1, 1'b0);
    chk("lone_eop_count", count, 12);
    chk("lone_eop_active", active, 0);

    // Async reset mid-frame
    sel = 2'd0;
    beat(1'b1, 1'b0, 1'b0);
    beat(1'b0, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1;
    chk("ar_use", use_flags, 0);
    chk("ar_freq", freq_out, 0);
    chk("ar_active", active, 0);
    chk("ar_count", count, 0);
    chk("ar_pend", pend, 0);
    #2 reset = 1'b0;
    tick();
    sel = 2'd1;
    fx = 1'b1;
    send_frame(3, 1'b0);
    chk("ar_track_count", count, 1);
    chk("ar_track_use", use_flags, 4'b0010);
    fx = 1'b0;
    tick();
    chk("bypass_use", use_flags, 0);
    tick();

    done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
